// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: multi-lane RVFI retirement capture with order tagging,
// packet normalisation and a DEPTH-entry first-word fall-through FIFO that
// drains one packet per cycle over a valid/ready handshake.
// Optional build macro RVFI_TRACE_HALT_EN adds a 'halt' input that suspends
// capture (no order increment, no drop counting) and forces stall_req high.
module rvfi_trace_fifo #(
  parameter int XLEN    = 32,
  parameter int NRET    = 2,
  parameter int DEPTH   = 16,
  parameter int ORDER_W = 64,
  parameter int DROP_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef RVFI_TRACE_HALT_EN
  input  logic                       halt,
`endif
  input  logic [NRET-1:0]            ret_valid,
  input  logic [NRET*XLEN-1:0]       ret_pc_rdata,
  input  logic [NRET*XLEN-1:0]       ret_pc_wdata,
  input  logic [NRET*32-1:0]         ret_insn,
  input  logic [NRET-1:0]            ret_trap,
  input  logic [NRET*5-1:0]          ret_rd_addr,
  input  logic [NRET*XLEN-1:0]       ret_rd_wdata,
  input  logic [NRET*2-1:0]          ret_mem_size,
  input  logic [NRET-1:0]            ret_mem_we,
  input  logic [NRET*XLEN-1:0]       ret_mem_addr,
  input  logic [NRET*XLEN-1:0]       ret_mem_data,
  output logic                       stall_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ORDER_W-1:0]         out_order,
  output logic [XLEN-1:0]            out_pc_rdata,
  output logic [XLEN-1:0]            out_pc_wdata,
  output logic [XLEN-1:0]            out_rd_wdata,
  output logic [XLEN-1:0]            out_mem_addr,
  output logic [XLEN-1:0]            out_mem_rdata,
  output logic [XLEN-1:0]            out_mem_wdata,
  output logic [31:0]                out_insn,
  output logic                       out_trap,
  output logic [4:0]                 out_rd_addr,
  output logic [XLEN/8-1:0]          out_mem_rmask,
  output logic [XLEN/8-1:0]          out_mem_wmask,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       lane_err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int MW  = XLEN / 8;
  localparam int DW1 = DROP_W + 1;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic [31:0]        insn;
    logic               trap;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rd_wdata;
    logic [XLEN-1:0]    mem_addr;
    logic [XLEN-1:0]    mem_rdata;
    logic [XLEN-1:0]    mem_wdata;
    logic [MW-1:0]      mem_rmask;
    logic [MW-1:0]      mem_wmask;
  } pkt_t;

  // Trapped instructions carry no architectural side effects; x0 writes are
  // invisible; masks are LSB-aligned and routed to the read or write side.
  function automatic pkt_t normalise(
    input logic [XLEN-1:0] pc_r,
    input logic [XLEN-1:0] pc_w,
    input logic [31:0]     insn,
    input logic            trap,
    input logic [4:0]      rd,
    input logic [XLEN-1:0] rdw,
    input logic [1:0]      size,
    input logic            we,
    input logic [XLEN-1:0] addr,
    input logic [XLEN-1:0] data
  );
    pkt_t          p;
    logic [MW-1:0] mask;
    p          = '0;
    p.pc_rdata = pc_r;
    p.pc_wdata = pc_w;
    p.insn     = insn;
    p.trap     = trap;
    p.mem_addr = addr;
    case (size)
      2'd1:    mask = MW'(4'h1);
      2'd2:    mask = MW'(4'h3);
      2'd3:    mask = MW'(4'hF);
      default: mask = '0;
    endcase
    if (!trap) begin
      p.rd_addr  = rd;
      p.rd_wdata = (rd == 5'd0) ? '0 : rdw;
      if (size != 2'd0) begin
        if (we) begin
          p.mem_wmask = mask;
          p.mem_wdata = data;
        end else begin
          p.mem_rmask = mask;
          p.mem_rdata = data;
        end
      end
    end
    return p;
  endfunction

  pkt_t               mem [DEPTH];
  pkt_t               lane_pkt [NRET];
  logic [PW-1:0]      wptr, rptr;
  logic [ORDER_W-1:0] order_cnt;
  logic [NRET-1:0]    run_mask;
  logic [LW-1:0]      k;
  logic               gap;
  logic               cap_en;
  logic               pop;
  logic [LW-1:0]      free;
  logic               accept;
  logic [LW-1:0]      level_nxt;
  logic               stall_nxt;
  logic [DW1-1:0]     drop_sum;

`ifdef RVFI_TRACE_HALT_EN
  assign cap_en = ~halt;
`else
  assign cap_en = 1'b1;
`endif

  // Count the contiguous run of valid lanes from lane 0 and flag any gap.
  always_comb begin
    logic run;
    run      = 1'b1;
    run_mask = '0;
    k        = '0;
    for (int i = 0; i < NRET; i++) begin
      run         = run & ret_valid[i];
      run_mask[i] = run;
      if (run) k = k + LW'(1);
    end
    gap = |(ret_valid & ~run_mask);
    if (!cap_en) begin
      k   = '0;
      gap = 1'b0;
    end
  end

  // Build normalised, order-tagged packets for every lane.
  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      lane_pkt[i] = normalise(ret_pc_rdata[i*XLEN +: XLEN], ret_pc_wdata[i*XLEN +: XLEN],
                              ret_insn[i*32 +: 32], ret_trap[i], ret_rd_addr[i*5 +: 5],
                              ret_rd_wdata[i*XLEN +: XLEN], ret_mem_size[i*2 +: 2],
                              ret_mem_we[i], ret_mem_addr[i*XLEN +: XLEN],
                              ret_mem_data[i*XLEN +: XLEN]);
      lane_pkt[i].order = order_cnt + ORDER_W'(i);
    end
  end

  // Admission: the entry popped this cycle is already free for this cycle's push.
  always_comb begin
    pop       = out_valid & out_ready;
    free      = LW'(DEPTH) - level + LW'(pop);
    accept    = (k <= free);
    level_nxt = level + (accept ? k : LW'(0)) - LW'(pop);
    stall_nxt = ((LW'(DEPTH) - level_nxt) < LW'(NRET)) | ~cap_en;
    drop_sum  = {1'b0, drop_cnt} + DW1'(k);
  end

  // Control state: pointers, occupancy, order/drop counters, sticky error, stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      order_cnt <= '0;
      drop_cnt  <= '0;
      lane_err  <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      order_cnt <= order_cnt + ORDER_W'(k);
      level     <= level_nxt;
      stall_req <= stall_nxt;
      if (gap) lane_err <= 1'b1;
      if (pop) rptr <= rptr + PW'(1);
      if (accept) wptr <= wptr + PW'(k);
      if (!accept) drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  // Packet storage: lanes land in consecutive slots starting at wptr.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NRET; i++) begin
        if (LW'(i) < k) mem[wptr + PW'(i)] <= lane_pkt[i];
      end
    end
  end

  assign out_valid     = (level != '0);
  assign out_order     = mem[rptr].order;
  assign out_pc_rdata  = mem[rptr].pc_rdata;
  assign out_pc_wdata  = mem[rptr].pc_wdata;
  assign out_insn      = mem[rptr].insn;
  assign out_trap      = mem[rptr].trap;
  assign out_rd_addr   = mem[rptr].rd_addr;
  assign out_rd_wdata  = mem[rptr].rd_wdata;
  assign out_mem_addr  = mem[rptr].mem_addr;
  assign out_mem_rdata = mem[rptr].mem_rdata;
  assign out_mem_wdata = mem[rptr].mem_wdata;
  assign out_mem_rmask = mem[rptr].mem_rmask;
  assign out_mem_wmask = mem[rptr].mem_wmask;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// tb_rvfi_trace_fifo: table-driven normalisation vectors, multi-lane streams,
// overflow/backpressure, lane-gap and mid-stream reset sequences, with a
// scoreboard queue checked at the consumer handshake.
module tb_rvfi_trace_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ret_valid;
  logic [63:0] ret_pc_rdata, ret_pc_wdata, ret_rd_wdata, ret_mem_addr, ret_mem_data, ret_insn;
  logic [1:0]  ret_trap, ret_mem_we;
  logic [9:0]  ret_rd_addr;
  logic [3:0]  ret_mem_size;
  logic        stall_req, out_valid, out_ready, out_trap, lane_err;
  logic [63:0] out_order;
  logic [31:0] out_pc_rdata, out_pc_wdata, out_rd_wdata, out_mem_addr, out_mem_rdata, out_mem_wdata, out_insn;
  logic [4:0]  out_rd_addr, level;
  logic [3:0]  out_mem_rmask, out_mem_wmask;
  logic [15:0] drop_cnt;

  rvfi_trace_fifo dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RVFI_TRACE_HALT_EN
    .halt(1'b0),
`endif
    .ret_valid(ret_valid), .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata),
    .ret_insn(ret_insn), .ret_trap(ret_trap), .ret_rd_addr(ret_rd_addr),
    .ret_rd_wdata(ret_rd_wdata), .ret_mem_size(ret_mem_size), .ret_mem_we(ret_mem_we),
    .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data), .stall_req(stall_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata), .out_rd_wdata(out_rd_wdata),
    .out_mem_addr(out_mem_addr), .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
    .out_insn(out_insn), .out_trap(out_trap), .out_rd_addr(out_rd_addr),
    .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask), .level(level),
    .drop_cnt(drop_cnt), .lane_err(lane_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, insn;
    logic        trap;
    logic [4:0]  rd;
    logic [31:0] rdw;
    logic [1:0]  size;
    logic        we;
    logic [31:0] addr, data;
  } lane_t;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc_r, pc_w, insn;
    logic        trap;
    logic [4:0]  rd;
    logic [31:0] rdw, addr, rdata, wdata;
    logic [3:0]  rmask, wmask;
  } exp_t;

  typedef struct {
    lane_t       in;
    logic [4:0]  rd;
    logic [31:0] rdw;
    logic [3:0]  rm, wm;
    logic [31:0] rdata, wdata;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_a, mon_e;
  vec_t        vt[8];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] tb_ord  = 0;
  lane_t       idle_l  = '0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Consumer side: every accepted head must match the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_a.order = out_order;     mon_a.pc_r  = out_pc_rdata; mon_a.pc_w  = out_pc_wdata;
      mon_a.insn  = out_insn;      mon_a.trap  = out_trap;     mon_a.rd    = out_rd_addr;
      mon_a.rdw   = out_rd_wdata;  mon_a.addr  = out_mem_addr; mon_a.rdata = out_mem_rdata;
      mon_a.wdata = out_mem_wdata; mon_a.rmask = out_mem_rmask; mon_a.wmask = out_mem_wmask;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pkt_extra: got order %0d expected no packet", out_order);
      end else begin
        mon_e = sb.pop_front();
        check("pkt", 512'(mon_a), 512'(mon_e));
      end
    end
  end

  function automatic lane_t plain(input int n);
    lane_t l;
    l      = '0;
    l.pc   = 32'h1000 + 32'(n) * 4;
    l.insn = 32'h0000_0013 | (32'(n) << 20);
    l.rd   = 5'(n % 31 + 1);
    l.rdw  = 32'(n) * 32'h11 + 32'h1;
    return l;
  endfunction

  function automatic exp_t plain_exp(input lane_t l, input logic [63:0] ord);
    exp_t e;
    e       = '0;
    e.order = ord;
    e.pc_r  = l.pc;
    e.pc_w  = l.pc + 32'd4;
    e.insn  = l.insn;
    e.rd    = l.rd;
    e.rdw   = l.rdw;
    return e;
  endfunction

  // Present one retire cycle; returns at posedge+1 with ret_valid dropped.
  task automatic drive(input logic [1:0] v, input lane_t l0, input lane_t l1);
    lane_t l[2];
    l[0] = l0;
    l[1] = l1;
    for (int i = 0; i < 2; i++) begin
      ret_pc_rdata[i*32 +: 32] = l[i].pc;
      ret_pc_wdata[i*32 +: 32] = l[i].pc + 32'd4;
      ret_insn[i*32 +: 32]     = l[i].insn;
      ret_trap[i]              = l[i].trap;
      ret_rd_addr[i*5 +: 5]    = l[i].rd;
      ret_rd_wdata[i*32 +: 32] = l[i].rdw;
      ret_mem_size[i*2 +: 2]   = l[i].size;
      ret_mem_we[i]            = l[i].we;
      ret_mem_addr[i*32 +: 32] = l[i].addr;
      ret_mem_data[i*32 +: 32] = l[i].data;
    end
    ret_valid = v;
    @(posedge clk);
    #1;
    ret_valid = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    ret_valid = 2'b00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    sb.delete();
    tb_ord = 0;
  endtask

  task automatic wait_drain(input string nm);
    int cyc;
    out_ready = 1'b1;
    cyc = 0;
    while ((level != 0 || sb.size() != 0) && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_level"}, 512'(level), 512'(0));
    check({nm, "_sb_empty"}, 512'(sb.size()), 512'(0));
  endtask

  initial begin
    exp_t  e;
    lane_t l;
    // pc, insn, trap, rd, rdw, size, we, addr, data -> rd, rdw, rmask, wmask, rdata, wdata
    vt[0] = '{'{32'h100, 32'h00500093, 1'b0, 5'd1, 32'd5, 2'd0, 1'b0, 32'h0, 32'h0}, 5'd1, 32'd5, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[1] = '{'{32'h104, 32'h0031a023, 1'b1, 5'd3, 32'd7, 2'd3, 1'b1, 32'h2000, 32'h1234}, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[2] = '{'{32'h108, 32'h00000013, 1'b0, 5'd0, 32'hDEAD, 2'd0, 1'b0, 32'h0, 32'h0}, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[3] = '{'{32'h10C, 32'h00f11123, 1'b0, 5'd0, 32'h0, 2'd2, 1'b1, 32'h1002, 32'hBEEF}, 5'd0, 32'h0, 4'h0, 4'h3, 32'h0, 32'hBEEF};
    vt[4] = '{'{32'h110, 32'h00118283, 1'b0, 5'd5, 32'h7F, 2'd1, 1'b0, 32'h3001, 32'h7F}, 5'd5, 32'h7F, 4'h1, 4'h0, 32'h7F, 32'h0};
    vt[5] = '{'{32'h114, 32'h00a02823, 1'b0, 5'd0, 32'h0, 2'd3, 1'b1, 32'h10, 32'hCAFEF00D}, 5'd0, 32'h0, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D};
    vt[6] = '{'{32'h118, 32'h01002383, 1'b0, 5'd7, 32'h12345678, 2'd3, 1'b0, 32'h20, 32'h12345678}, 5'd7, 32'h12345678, 4'hF, 4'h0, 32'h12345678, 32'h0};
    vt[7] = '{'{32'h11C, 32'h00030303, 1'b1, 5'd6, 32'h99, 2'd1, 1'b0, 32'h40, 32'h55}, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};

    ret_valid = '0; ret_pc_rdata = '0; ret_pc_wdata = '0; ret_insn = '0; ret_trap = '0;
    ret_rd_addr = '0; ret_rd_wdata = '0; ret_mem_size = '0; ret_mem_we = '0;
    ret_mem_addr = '0; ret_mem_data = '0; out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_level", 512'(level), 512'(0));
    check("rst_drop", 512'(drop_cnt), 512'(0));
    check("rst_lane_err", 512'(lane_err), 512'(0));
    check("rst_stall", 512'(stall_req), 512'(0));

    // Single lane-0 retire is visible the following cycle
    drive(2'b01, vt[0].in, idle_l);
    check("t1_out_valid", 512'(out_valid), 512'(1));
    check("t1_order", 512'(out_order), 512'(0));
    check("t1_rd_wdata", 512'(out_rd_wdata), 512'(5));
    check("t1_masks", 512'({out_mem_rmask, out_mem_wmask}), 512'(0));
    check("t1_level", 512'(level), 512'(1));
    e = plain_exp(vt[0].in, tb_ord);
    sb.push_back(e);
    tb_ord = tb_ord + 1;
    wait_drain("t1");

    // Normalisation table, one packet per cycle with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, vt[i].in, idle_l);
      e       = plain_exp(vt[i].in, tb_ord);
      e.trap  = vt[i].in.trap;
      e.rd    = vt[i].rd;
      e.rdw   = vt[i].rdw;
      e.addr  = vt[i].in.addr;
      e.rmask = vt[i].rm;
      e.wmask = vt[i].wm;
      e.rdata = vt[i].rdata;
      e.wdata = vt[i].wdata;
      sb.push_back(e);
      tb_ord = tb_ord + 1;
    end
    wait_drain("table");

    // Two lanes for three cycles: lane 0 drains before lane 1
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, plain(2 * c), plain(2 * c + 1));
      sb.push_back(plain_exp(plain(2 * c), tb_ord));
      sb.push_back(plain_exp(plain(2 * c + 1), tb_ord + 1));
      tb_ord = tb_ord + 2;
    end
    wait_drain("dual");

    // Lane gap: nothing captured, order not advanced, error sticky
    drive(2'b10, plain(40), plain(41));
    check("gap_lane_err", 512'(lane_err), 512'(1));
    check("gap_level", 512'(level), 512'(0));
    drive(2'b01, plain(42), idle_l);
    sb.push_back(plain_exp(plain(42), tb_ord));
    tb_ord = tb_ord + 1;
    wait_drain("gap");
    check("gap_sticky", 512'(lane_err), 512'(1));

    // Reset mid-stream discards buffered packets and restarts order
    out_ready = 1'b0;
    drive(2'b11, plain(43), plain(44));
    check("pre_rst_level", 512'(level), 512'(2));
    do_reset();
    check("mrst_level", 512'(level), 512'(0));
    check("mrst_out_valid", 512'(out_valid), 512'(0));
    check("mrst_lane_err", 512'(lane_err), 512'(0));
    drive(2'b01, plain(45), idle_l);
    check("mrst_order", 512'(out_order), 512'(0));
    sb.push_back(plain_exp(plain(45), tb_ord));
    tb_ord = tb_ord + 1;
    wait_drain("mrst");

    // Overflow with the consumer stalled
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(2'b11, plain(2 * c), plain(2 * c + 1));
      sb.push_back(plain_exp(plain(2 * c), tb_ord));
      sb.push_back(plain_exp(plain(2 * c + 1), tb_ord + 1));
      tb_ord = tb_ord + 2;
      check($sformatf("ovf_level_%0d", c), 512'(level), 512'(2 * c + 2));
      check($sformatf("ovf_stall_%0d", c), 512'(stall_req), 512'(c == 7));
    end
    drive(2'b11, plain(16), plain(17));
    tb_ord = tb_ord + 2;
    check("ovf_drop", 512'(drop_cnt), 512'(2));
    check("ovf_full_level", 512'(level), 512'(16));

    // Push of one lane while popping at full reuses the freed entry
    out_ready = 1'b1;
    drive(2'b01, plain(18), idle_l);
    sb.push_back(plain_exp(plain(18), tb_ord));
    tb_ord = tb_ord + 1;
    check("full_pp_level", 512'(level), 512'(16));
    check("full_pp_drop", 512'(drop_cnt), 512'(2));
    check("full_pp_stall", 512'(stall_req), 512'(1));
    idle(3);
    check("drain_level", 512'(level), 512'(13));
    drive(2'b11, plain(19), plain(20));
    sb.push_back(plain_exp(plain(19), tb_ord));
    sb.push_back(plain_exp(plain(20), tb_ord + 1));
    tb_ord = tb_ord + 2;
    wait_drain("ovf");
    check("ovf_drop_final", 512'(drop_cnt), 512'(2));
    check("ovf_stall_clear", 512'(stall_req), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_fifo.md
Name: rvfi_trace_fifo

Overview:
- Parametrised successor to the single-retire RVFI-ext monitor.
- Captures up to NRET retirement packets per cycle from the core's retire ports and tags each with a monotonic order number.
- Normalises each packet: zeroes fields for traps and rd=x0, and derives memory masks from access size.
- Buffers packets in a DEPTH-entry FIFO and drains one packet per cycle to the DPI/host trace consumer over a valid/ready handshake, with core backpressure and overflow accounting.

Parameters:
- XLEN, 32, data/address width
- NRET, 2, retire lanes per cycle (1..4)
- DEPTH, 16, FIFO entries; power of two, >= 2*NRET
- ORDER_W, 64, width of order counter
- DROP_W, 16, width of saturating drop counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ret_valid  in  NRET  per-lane retire valid; lane 0 is oldest
- ret_pc_rdata  in  NRET*XLEN  PC of retired instr
- ret_pc_wdata  in  NRET*XLEN  next PC including trap redirect
- ret_insn  in  NRET*32  instruction word
- ret_trap  in  NRET  instruction trapped
- ret_rd_addr  in  NRET*5  destination register
- ret_rd_wdata  in  NRET*XLEN  rd write value
- ret_mem_size  in  NRET*2  0 none, 1 byte, 2 half, 3 word
- ret_mem_we  in  NRET  1 store, 0 load
- ret_mem_addr  in  NRET*XLEN  effective address
- ret_mem_data  in  NRET*XLEN  load data or store data
- stall_req  out  1  core must not retire next cycle
- out_valid  out  1  head packet valid
- out_ready  in  1  consumer accepts head
- out_order  out  ORDER_W  order number of head
- out_pc_rdata, out_pc_wdata, out_rd_wdata, out_mem_addr, out_mem_rdata, out_mem_wdata  out  XLEN each  head fields
- out_insn  out  32  head instruction
- out_trap  out  1  head trap flag
- out_rd_addr  out  5  head rd
- out_mem_rmask, out_mem_wmask  out  XLEN/8 each  byte masks
- level  out  $clog2(DEPTH)+1  occupancy
- drop_cnt  out  DROP_W  packets lost to overflow, saturating
- lane_err  out  1  sticky: non-contiguous ret_valid seen

Behaviour:
- Reset (rst_n low at posedge): pointers, level, order counter and drop_cnt cleared; out_valid=0; lane_err=0; stall_req=0. Reset mid-operation discards all buffered packets.
- Lane validity: ret_valid must be contiguous from lane 0. Any gap sets lane_err (sticky until reset); only lanes below the first invalid lane are captured.
- Let k = number of captured lanes. Lane i receives order = order_cnt + i. order_cnt += k every cycle, including dropped packets, so the consumer sees gaps in the order sequence.
- Admission: if k <= free entries, all k are written in lane order. Otherwise none are written (all-or-nothing per cycle) and drop_cnt += k, saturating at all-ones.
- free includes the entry popped in the same cycle: free = DEPTH - level + (out_valid & out_ready).
- stall_req is registered: asserted when next-cycle free < NRET.
- Normalisation at write:
  - trap: rd_addr, rd_wdata, both masks and mem data forced to 0.
  - rd_addr==0: rd_wdata forced to 0.
  - mem_size 1/2/3 gives mask 0x1/0x3/0xF, LSB-aligned (not shifted by address). mem_size 0 gives masks 0.
  - we=1: wmask and wdata set; rmask and rdata = 0.
  - we=0: rmask and rdata set; wmask and wdata = 0.
- Latency: a packet written at cycle N is visible on out_* at N+1 at the earliest. Output is registered and first-word fall-through.
- Handshake: pop occurs when out_valid & out_ready. out_* are held stable while out_valid & ~out_ready. out_ready with out_valid=0 is ignored.
- Simultaneous push and pop at full: the pop frees an entry used by the same cycle's push; level = level + k - pop.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH.

Optional Feature:
- Macro: RVFI_TRACE_HALT_EN.
- Defined: adds input port halt (1 bit). While halt=1, ret_valid is ignored: no capture, no order increment, no drop counting. Draining continues and stall_req is forced to 1.
- Undefined: no halt port; capture is always enabled.

Test Plan:
- Single lane 0 retire (pc=0x100, insn=0x00500093, rd=1, wdata=5) -> next cycle out_valid=1, order=0, rd_wdata=5, masks 0.
- NRET=2, lanes 0 and 1 valid for 3 cycles with out_ready=1 -> six packets drained in order 0..5, lane 0 before lane 1.
- out_ready=0, DEPTH=16, NRET=2, 9 retire cycles -> level=16, stall_req high once free<2, ninth cycle drop_cnt=2, next accepted order skips 16,17.
- Lane with trap=1, rd=3, size=3 store -> out_rd_addr=0, rd_wdata=0, wmask=0. Separate lane with rd=0, wdata=0xDEAD -> out_rd_wdata=0.
- Store size=2 at addr 0x1002, data 0xBEEF -> wmask=0x3, wdata=0xBEEF, rmask=0. Load size=1 -> rmask=0x1, wmask=0.
- ret_valid=2'b10 -> lane_err=1, nothing captured. Then rst_n low for one cycle mid-stream -> level=0, out_valid=0, order restarts at 0, lane_err cleared.
